// File: rtl/jstk_spi_reader.sv
// SPI mode-0 master that polls the PmodJSTK every POLL_PERIOD cycles and
// publishes the raw X/Y stick position and button bits from a 5-byte frame.
module jstk_spi_reader #(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned SS_SETUP    = 1500,
  parameter int unsigned BYTE_GAP    = 1000,
  parameter int unsigned POLL_PERIOD = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] led_cmd,
  input  logic       MISO,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] buttons,
  output logic       sample_valid,
  output logic       busy
);

  localparam int unsigned MAX_A   = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int unsigned MAX_B   = (BYTE_GAP > POLL_PERIOD) ? BYTE_GAP : POLL_PERIOD;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [6:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [1:0]       led_q, led_d;
  logic [7:0]       x_lo_q, x_lo_d, y_lo_q, y_lo_d;
  logic [1:0]       x_hi_q, x_hi_d, y_hi_q, y_hi_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       btn_q, btn_d;
  logic             ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic             valid_q, valid_d, busy_q, busy_d;

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      led_q   <= '0;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_lo_q  <= '0;
      y_hi_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      led_q   <= led_d;
      x_lo_q  <= x_lo_d;
      x_hi_q  <= x_hi_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    led_d   = led_q;
    x_lo_d  = x_lo_q;
    x_hi_d  = x_hi_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (cnt_q == POLL_LAST) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          ss_d    = 1'b0;
          led_d   = led_cmd;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          // Byte0 is {6'b100000, led}: MSB goes out now, the rest is queued.
          state_d = ST_SHIFT;
          cnt_d   = '0;
          byte_d  = '0;
          bit_d   = '0;
          mosi_d  = 1'b1;
          tx_d    = {5'b00000, led_q};
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], MISO};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              mosi_d = 1'b0;
              case (byte_q)
                3'd0:    x_lo_d = rx_q;
                3'd1:    x_hi_d = rx_q[1:0];
                3'd2:    y_lo_d = rx_q;
                3'd3:    y_hi_d = rx_q[1:0];
                default: ;
              endcase
              if (byte_q == 3'd4) begin
                state_d = ST_DONE;
                ss_d    = 1'b1;
                x_d     = {x_hi_q, x_lo_q};
                y_d     = {y_hi_q, y_lo_q};
                btn_d   = rx_q[2:0];
                valid_d = 1'b1;
              end else begin
                state_d = ST_GAP;
              end
            end else begin
              bit_d  = 3'(bit_q + 3'd1);
              mosi_d = tx_q[6];
              tx_d   = {tx_q[5:0], 1'b0};
            end
          end
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          byte_d  = 3'(byte_q + 3'd1);
          bit_d   = '0;
          tx_d    = '0;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ss_d    = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign SS           = ss_q;
  assign SCLK         = sclk_q;
  assign MOSI         = mosi_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign buttons      = btn_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule
